// File: rtl/rx_frame_controller.sv
// Receive frame controller: edge-detects decoder frame-complete, filters by destination address,
// and buffers accepted frames in a small FIFO for the host, with drop/overflow accounting.
module rx_frame_controller #(
  parameter int unsigned                FRAME_SIZE = 16,
  parameter int unsigned                ADDR_WIDTH = 4,
  parameter logic [ADDR_WIDTH-1:0]      MY_ADDR    = 4'h1,
  parameter int unsigned                DEPTH      = 4,
  localparam int unsigned               PtrW       = $clog2(DEPTH),
  localparam int unsigned               LvlW       = PtrW + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [FRAME_SIZE-1:0] dec_data,
  input  logic                  dec_irq,
  output logic                  dec_reset,
  output logic [FRAME_SIZE-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LvlW-1:0]       fifo_level,
  output logic [7:0]            frame_count,
  output logic [7:0]            drop_count,
  output logic                  overflow
);

  typedef enum logic [1:0] {StOff, StFlush, StRun} state_e;

  state_e                r_state, w_state_next;
  logic                  r_flush_cnt;
  logic                  r_dec_reset;
  logic                  r_irq;
  logic [FRAME_SIZE-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]       r_wr_ptr, r_rd_ptr;
  logic [LvlW-1:0]       r_level;
  logic [7:0]            r_frame_cnt, r_drop_cnt;
  logic                  r_overflow;

  logic [ADDR_WIDTH-1:0] w_dest;
  logic                  w_event, w_addressed, w_full, w_pop, w_push, w_drop, w_ovf_set, w_clear;

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StOff:   if (enable) w_state_next = StFlush;
      StFlush: begin
        if (!enable)          w_state_next = StOff;
        else if (r_flush_cnt) w_state_next = StRun;
      end
      StRun: begin
        if (!enable)    w_state_next = StOff;
        else if (flush) w_state_next = StFlush;
      end
      default: w_state_next = StOff;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state     <= StOff;
      r_flush_cnt <= 1'b0;
      r_dec_reset <= 1'b1;
      r_irq       <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= (r_state == StFlush) && (w_state_next == StFlush);
      r_dec_reset <= (w_state_next != StRun);
      r_irq       <= dec_irq;
    end
  end

  // Events are only honoured in RUN and are discarded when the same cycle leaves RUN.
  always_comb begin
    w_dest      = dec_data[FRAME_SIZE-1 -: ADDR_WIDTH];
    w_addressed = (w_dest == MY_ADDR) || (&w_dest);
    w_event     = dec_irq && !r_irq && (r_state == StRun) && enable && !flush;
    w_full      = (r_level == LvlW'(DEPTH));
    w_pop       = out_valid && out_ready;
    w_push      = w_event && w_addressed && (!w_full || w_pop);
    w_ovf_set   = w_event && w_addressed && w_full && !w_pop;
    w_drop      = (w_event && !w_addressed) || w_ovf_set;
    w_clear     = (w_state_next != StRun);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (w_clear) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= dec_data;
        r_wr_ptr        <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PtrW'(1);
      if (w_push && !w_pop)      r_level <= r_level + LvlW'(1);
      else if (w_pop && !w_push) r_level <= r_level - LvlW'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_frame_cnt <= '0;
      r_drop_cnt  <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_push && (r_frame_cnt != 8'hFF)) r_frame_cnt <= r_frame_cnt + 8'd1;
      if (w_drop && (r_drop_cnt != 8'hFF))  r_drop_cnt  <= r_drop_cnt + 8'd1;
      if (flush && (r_state == StRun)) r_overflow <= 1'b0;
      else if (w_ovf_set)              r_overflow <= 1'b1;
    end
  end

  assign dec_reset   = r_dec_reset;
  assign out_data    = r_mem[r_rd_ptr];
  assign out_valid   = (r_level != '0);
  assign fifo_level  = r_level;
  assign frame_count = r_frame_cnt;
  assign drop_count  = r_drop_cnt;
  assign overflow    = r_overflow;

endmodule

// File: doc/rx_frame_controller.md
RX_FRAME_CONTROLLER -- requirements
Module: rx_frame_controller

Interface
REQ-001 SHALL have parameter FRAME_SIZE, default 16, decoder frame width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, destination field = data[FRAME_SIZE-1 : FRAME_SIZE-ADDR_WIDTH].
REQ-003 SHALL have parameter MY_ADDR, default 4'h1, local node address.
REQ-004 SHALL have parameter DEPTH, default 4, frame FIFO entries (power of 2, >=2).
REQ-005 SHALL have ports: clock  in  1  system clock; reset  in  1  asynchronous active-high reset.
REQ-006 SHALL have ports: enable  in  1  receive enable; flush  in  1  one-cycle request to drop FIFO and restart decoder.
REQ-007 SHALL have ports: dec_data  in  FRAME_SIZE  decoder frame; dec_irq  in  1  decoder frame-complete level; dec_reset  out  1  synchronous reset to decoder.
REQ-008 SHALL have ports: out_data  out  FRAME_SIZE  head frame; out_valid  out  1  head valid; out_ready  in  1  host accepts.
REQ-009 SHALL have ports: fifo_level  out  log2(DEPTH)+1  occupancy; frame_count  out  8  accepted frames; drop_count  out  8  dropped frames; overflow  out  1  sticky overflow flag.

Function
REQ-010 SHALL register dec_irq into irq_q; a frame event is dec_irq=1 and irq_q=0, sampled only in state RUN.
REQ-011 SHALL capture dec_data on the frame-event cycle (zero extra latency); frame is addressed if destination field equals MY_ADDR or all ones.
REQ-012 SHALL implement FSM states OFF, FLUSH, RUN; OFF->FLUSH when enable=1; FLUSH->RUN after exactly 2 cycles; RUN->FLUSH on flush=1; any state->OFF when enable=0 (priority over flush).
REQ-013 SHALL drive dec_reset=1 in OFF and FLUSH, 0 in RUN (registered, from FSM state).
REQ-014 SHALL empty FIFO (pointers and level to 0) on every entry into FLUSH or OFF; counters and overflow unaffected.
REQ-015 SHALL push addressed frames into FIFO; pushed frame visible at out_data/out_valid the cycle after the event.
REQ-016 SHALL pop when out_valid=1 and out_ready=1; out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-017 SHALL accept push and pop in the same cycle at any level, including full (level unchanged).
REQ-018 SHALL drop a frame event when FIFO full and no same-cycle pop: set overflow=1, increment drop_count.
REQ-019 SHALL increment drop_count for non-addressed frames; overflow not set for these.
REQ-020 SHALL increment frame_count for each pushed frame.
REQ-021 SHALL saturate frame_count and drop_count at 255.
REQ-022 SHALL clear overflow only via reset or flush=1 in RUN.
REQ-023 SHALL ignore out_ready when out_valid=0; FIFO pointers wrap modulo DEPTH.
REQ-024 SHALL ignore a frame event coinciding with flush=1 or enable=0 (not pushed, not counted).

Reset
REQ-025 SHALL on reset=1 immediately set state OFF, dec_reset=1, out_valid=0, out_data=0, fifo_level=0, frame_count=0, drop_count=0, overflow=0, irq_q=0.
REQ-026 SHALL after reset release remain in OFF until enable=1; reset mid-transfer discards all FIFO contents.

Verification
REQ-027 SHALL cover: enable=1 from reset -> dec_reset high 3 cycles (OFF + 2 FLUSH) then 0; out_valid=0.
REQ-028 SHALL cover: frame 16'h1ABC with irq rise, out_ready=0 -> out_valid=1 next cycle, out_data=16'h1ABC, fifo_level=1, frame_count=1.
REQ-029 SHALL cover: frames 16'h2000 and 16'hF123 -> first dropped (drop_count=1), second accepted (broadcast), frame_count=1.
REQ-030 SHALL cover: 5 addressed frames, out_ready=0, DEPTH=4 -> fifo_level=4, overflow=1, drop_count=1; pops return first four frames in order.
REQ-031 SHALL cover: full FIFO, frame event with out_ready=1 same cycle -> fifo_level stays 4, no drop, overflow stays 0.
REQ-032 SHALL cover: flush=1 with level 3 and overflow=1 -> level 0, overflow=0, dec_reset=1 for 2 cycles, counters unchanged.
